// File: rtl/ddr3_frame_bank_ctrl.sv
// rtl/ddr3_frame_bank_ctrl.sv - triple-buffered frame bank controller ahead of the AXI DDR3 adapter
// Writer and reader each own one bank; the writer always picks a bank that is neither read nor newest.
module ddr3_frame_bank_ctrl #(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = 32'h0000_0000,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BANK_STRIDE        = 32'h0010_0000,
    parameter int                              FRAME_BYTES        = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start_in,
    input  logic                          pix_valid_in,
    input  logic [7:0]                    pix_data_in,
    output logic                          wr_begin,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_begin,
    output logic                          wr_data_valid,
    output logic [7:0]                    wr_data_in,
    input  logic                          rd_frame_req,
    input  logic                          rd_valid_in,
    output logic                          rd_enable,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_begin,
    output logic                          rd_nack,
    output logic                          rd_done,
    output logic                          frame_valid,
    output logic [1:0]                    wr_bank,
    output logic [1:0]                    rd_bank,
    output logic [1:0]                    last_bank,
    output logic                          short_frame_err
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int CW = $clog2(FRAME_BYTES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {W_IDLE, W_START, W_DATA, W_DONE} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} rstate_t;

    wstate_t        wst_q, wst_d;
    rstate_t        rst_q, rst_d;
    logic [1:0]     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, last_bank_q, last_bank_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic           wr_dv_q, wr_dv_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           frame_valid_q, frame_valid_d, short_err_q, short_err_d;
    logic           rd_nack_q, rd_nack_d, rd_done_q, rd_done_d;
    logic           start_sel;
    logic [3:0]     excl;
    logic [1:0]     free_bank;

    function automatic logic [AW-1:0] bank_base(input logic [1:0] b);
        case (b)
            2'd1:    return BASE_ADDR + BANK_STRIDE;
            2'd2:    return BASE_ADDR + BANK_STRIDE + BANK_STRIDE;
            default: return BASE_ADDR;
        endcase
    endfunction

    // Lowest bank not held by the reader and not holding the newest complete frame.
    always_comb begin
        excl = 4'b0000;
        if (frame_valid_q)    excl[last_bank_q] = 1'b1;
        if (rst_q != R_IDLE)  excl[rd_bank_q]   = 1'b1;
        if (!excl[0])         free_bank = 2'd0;
        else if (!excl[1])    free_bank = 2'd1;
        else                  free_bank = 2'd2;
    end

    always_comb begin
        wst_d         = wst_q;
        wr_bank_d     = wr_bank_q;
        wr_addr_d     = wr_addr_q;
        wr_cnt_d      = wr_cnt_q;
        wr_dv_d       = 1'b0;
        wr_data_d     = wr_data_q;
        last_bank_d   = last_bank_q;
        frame_valid_d = frame_valid_q;
        short_err_d   = short_err_q;
        start_sel     = 1'b0;
        case (wst_q)
            W_IDLE:  start_sel = frame_start_in;
            W_START: wst_d = W_DATA;
            W_DATA: begin
                if (frame_start_in) begin
                    short_err_d = 1'b1;
                    start_sel   = 1'b1;
                end else if (pix_valid_in) begin
                    wr_dv_d   = 1'b1;
                    wr_data_d = pix_data_in;
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == CNT_LAST) wst_d = W_DONE;
                end
            end
            W_DONE: begin
                last_bank_d   = wr_bank_q;
                frame_valid_d = 1'b1;
                wst_d         = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
        if (start_sel) begin
            wst_d     = W_START;
            wr_bank_d = free_bank;
            wr_addr_d = bank_base(free_bank);
            wr_cnt_d  = '0;
        end
    end

    // The accept uses last_bank_q, so a read coinciding with W_DONE gets the previous frame.
    always_comb begin
        rst_d     = rst_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        rd_cnt_d  = rd_cnt_q;
        rd_nack_d = 1'b0;
        rd_done_d = 1'b0;
        case (rst_q)
            R_IDLE: begin
                if (rd_frame_req) begin
                    if (frame_valid_q) begin
                        rd_bank_d = last_bank_q;
                        rd_addr_d = bank_base(last_bank_q);
                        rd_cnt_d  = '0;
                        rst_d     = R_START;
                    end else begin
                        rd_nack_d = 1'b1;
                    end
                end
            end
            R_START: rst_d = R_BUSY;
            R_BUSY: begin
                if (rd_valid_in) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == CNT_LAST) begin
                        rd_done_d = 1'b1;
                        rst_d     = R_IDLE;
                    end
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q         <= W_IDLE;
            rst_q         <= R_IDLE;
            wr_bank_q     <= 2'd0;
            rd_bank_q     <= 2'd0;
            last_bank_q   <= 2'd0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            wr_dv_q       <= 1'b0;
            wr_data_q     <= 8'd0;
            frame_valid_q <= 1'b0;
            short_err_q   <= 1'b0;
            rd_nack_q     <= 1'b0;
            rd_done_q     <= 1'b0;
        end else begin
            wst_q         <= wst_d;
            rst_q         <= rst_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            last_bank_q   <= last_bank_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_dv_q       <= wr_dv_d;
            wr_data_q     <= wr_data_d;
            frame_valid_q <= frame_valid_d;
            short_err_q   <= short_err_d;
            rd_nack_q     <= rd_nack_d;
            rd_done_q     <= rd_done_d;
        end
    end

    assign wr_begin        = (wst_q == W_START);
    assign rd_enable       = (rst_q == R_START);
    assign wr_addr_begin   = wr_addr_q;
    assign rd_addr_begin   = rd_addr_q;
    assign wr_data_valid   = wr_dv_q;
    assign wr_data_in      = wr_data_q;
    assign rd_nack         = rd_nack_q;
    assign rd_done         = rd_done_q;
    assign frame_valid     = frame_valid_q;
    assign wr_bank         = wr_bank_q;
    assign rd_bank         = rd_bank_q;
    assign last_bank       = last_bank_q;
    assign short_frame_err = short_err_q;
endmodule

// File: tb/tb_ddr3_frame_bank_ctrl.sv
// tb/tb_ddr3_frame_bank_ctrl.sv - self-checking bench for ddr3_frame_bank_ctrl
module tb_ddr3_frame_bank_ctrl;
    localparam int FB = 16;
    localparam int OP_WR = 0, OP_RQ = 1, OP_RV = 2;

    typedef struct {
        int         op;
        int         n;
        bit         ev;
        bit         fv;
        logic [1:0] bank;
    } vec_t;

    logic        clk, rst_n, frame_start_in, pix_valid_in, rd_frame_req, rd_valid_in;
    logic [7:0]  pix_data_in, wr_data_in;
    logic        wr_begin, wr_data_valid, rd_enable, rd_nack, rd_done, frame_valid, short_frame_err;
    logic [31:0] wr_addr_begin, rd_addr_begin;
    logic [1:0]  wr_bank, rd_bank, last_bank;

    int checks = 0, errors = 0;
    int n_wb = 0, n_re = 0, pw_viol = 0;
    logic [3:0] prev_p = 4'b0;
    logic [7:0] wrq[$];
    vec_t vecs[12];
    bit m_fv, m_act;
    logic [1:0] m_last, m_rd, b;

    ddr3_frame_bank_ctrl #(
        .C_M_AXI_ADDR_WIDTH(32), .BASE_ADDR(32'h0), .BANK_STRIDE(32'h1000), .FRAME_BYTES(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start_in(frame_start_in), .pix_valid_in(pix_valid_in),
        .pix_data_in(pix_data_in), .wr_begin(wr_begin), .wr_addr_begin(wr_addr_begin),
        .wr_data_valid(wr_data_valid), .wr_data_in(wr_data_in), .rd_frame_req(rd_frame_req),
        .rd_valid_in(rd_valid_in), .rd_enable(rd_enable), .rd_addr_begin(rd_addr_begin),
        .rd_nack(rd_nack), .rd_done(rd_done), .frame_valid(frame_valid), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .last_bank(last_bank), .short_frame_err(short_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_data_valid) wrq.push_back(wr_data_in);
        if (wr_begin)  n_wb <= n_wb + 1;
        if (rd_enable) n_re <= n_re + 1;
        if (|({wr_begin, rd_enable, rd_nack, rd_done} & prev_p)) pw_viol <= pw_viol + 1;
        prev_p <= {wr_begin, rd_enable, rd_nack, rd_done};
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input logic [1:0] bk);
        return 32'(bk) * 32'h1000;
    endfunction

    function automatic logic [1:0] model_free();
        for (int i = 0; i < 3; i++)
            if (!((m_fv && m_last == 2'(i)) || (m_act && m_rd == 2'(i)))) return 2'(i);
        return 2'd3;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({wr_begin, wr_data_valid, rd_enable, rd_nack, rd_done, frame_valid,
                                 short_frame_err, wr_bank, rd_bank, last_bank, wr_data_in}), 32'd0);
        chk({tag, "_wr_addr"}, wr_addr_begin, 32'd0);
        chk({tag, "_rd_addr"}, rd_addr_begin, 32'd0);
    endtask

    // Write one frame: a dropped byte in W_START, then nvalid bytes (optionally gapped).
    task automatic wr_frame(input int nvalid, input bit gaps, input logic [1:0] exp_bank, input string tag);
        logic [7:0] exp[$];
        int sent;
        bit v;
        wrq.delete();
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        chk({tag, "_wr_begin"}, 32'(wr_begin), 32'd1);
        chk({tag, "_wr_addr"}, wr_addr_begin, base_of(exp_bank));
        chk({tag, "_wr_bank"}, 32'(wr_bank), 32'(exp_bank));
        pix_valid_in = 1'b1;
        pix_data_in  = 8'hEE;
        cyc();
        sent = 0;
        while (sent < nvalid) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_valid_in = v;
            pix_data_in  = 8'($urandom);
            if (v) begin
                if (exp.size() < FB) exp.push_back(pix_data_in);
                sent++;
            end
            cyc();
        end
        pix_valid_in = 1'b0;
        repeat (3) cyc();
        chk({tag, "_wr_count"}, 32'(wrq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wrq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(wrq[i]), 32'(exp[i]));
        chk({tag, "_last_bank"}, 32'(last_bank), 32'(exp_bank));
    endtask

    task automatic rd_req(input bit ev, input logic [1:0] exp_bank, input string tag);
        rd_frame_req = 1'b1;
        cyc();
        rd_frame_req = 1'b0;
        chk({tag, "_rd_enable"}, 32'(rd_enable), 32'(ev));
        chk({tag, "_rd_nack"}, 32'(rd_nack), 32'(!ev));
        if (ev) begin
            chk({tag, "_rd_addr"}, rd_addr_begin, base_of(exp_bank));
            chk({tag, "_rd_bank"}, 32'(rd_bank), 32'(exp_bank));
        end
        cyc();
        cyc();
    endtask

    task automatic rd_pulses(input int n, input bit gaps);
        int sent;
        bit v;
        sent = 0;
        while (sent < n) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            rd_valid_in = v;
            if (v) sent++;
            cyc();
        end
        rd_valid_in = 1'b0;
    endtask

    initial begin
        int wb0, re0;
        rst_n = 1'b0; frame_start_in = 1'b0; pix_valid_in = 1'b0; pix_data_in = 8'd0;
        rd_frame_req = 1'b0; rd_valid_in = 1'b0;

        vecs[0]  = '{OP_RQ, 0,  1'b0, 1'b0, 2'd0};
        vecs[1]  = '{OP_WR, 16, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{OP_RQ, 0,  1'b1, 1'b1, 2'd0};
        vecs[3]  = '{OP_WR, 20, 1'b0, 1'b1, 2'd1};
        vecs[4]  = '{OP_WR, 16, 1'b0, 1'b1, 2'd2};
        vecs[5]  = '{OP_RV, 16, 1'b1, 1'b1, 2'd0};
        vecs[6]  = '{OP_RQ, 0,  1'b1, 1'b1, 2'd2};
        vecs[7]  = '{OP_WR, 16, 1'b0, 1'b1, 2'd0};
        vecs[8]  = '{OP_RV, 15, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{OP_RV, 1,  1'b1, 1'b1, 2'd0};
        vecs[10] = '{OP_RQ, 0,  1'b1, 1'b1, 2'd0};
        vecs[11] = '{OP_RV, 16, 1'b1, 1'b1, 2'd0};

        repeat (3) cyc();
        check_zero("reset");
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OP_WR: wr_frame(vecs[i].n, 1'b0, vecs[i].bank, $sformatf("vec%0d", i));
                OP_RQ: rd_req(vecs[i].ev, vecs[i].bank, $sformatf("vec%0d", i));
                default: begin
                    rd_pulses(vecs[i].n, 1'b0);
                    chk($sformatf("vec%0d_rd_done", i), 32'(rd_done), 32'(vecs[i].ev));
                    cyc();
                end
            endcase
            chk($sformatf("vec%0d_frame_valid", i), 32'(frame_valid), 32'(vecs[i].fv));
        end

        // Short frame: 5 bytes, then a restart with a coincident (dropped) byte.
        wrq.delete();
        frame_start_in = 1'b1; cyc(); frame_start_in = 1'b0; cyc();
        for (int i = 0; i < 5; i++) begin
            pix_valid_in = 1'b1; pix_data_in = 8'(i); cyc();
        end
        frame_start_in = 1'b1; pix_data_in = 8'h55; cyc();
        frame_start_in = 1'b0; pix_valid_in = 1'b0;
        chk("short_wr_begin", 32'(wr_begin), 32'd1);
        chk("short_wr_addr", wr_addr_begin, 32'h1000);
        chk("short_err", 32'(short_frame_err), 32'd1);
        chk("short_fv", 32'(frame_valid), 32'd1);
        chk("short_last_bank", 32'(last_bank), 32'd0);
        chk("short_bytes_before", 32'(wrq.size()), 32'd5);
        cyc();
        for (int i = 0; i < FB; i++) begin
            pix_valid_in = 1'b1; pix_data_in = 8'(8'h60 + i); cyc();
        end
        pix_valid_in = 1'b0;
        repeat (3) cyc();
        chk("short_bytes_total", 32'(wrq.size()), 32'd21);
        chk("short_last_byte", 32'(wrq[wrq.size()-1]), 32'h6F);
        chk("short_done_last_bank", 32'(last_bank), 32'd1);

        // Read request coinciding with W_DONE captures the previous frame's bank.
        frame_start_in = 1'b1; cyc(); frame_start_in = 1'b0;
        chk("coin_wr_addr", wr_addr_begin, 32'h0000);
        cyc();
        for (int i = 0; i < FB; i++) begin
            pix_valid_in = 1'b1; pix_data_in = 8'(i); cyc();
        end
        pix_valid_in = 1'b0; rd_frame_req = 1'b1; cyc(); rd_frame_req = 1'b0;
        chk("coin_rd_enable", 32'(rd_enable), 32'd1);
        chk("coin_rd_addr", rd_addr_begin, 32'h1000);
        chk("coin_last_bank", 32'(last_bank), 32'd0);
        cyc();
        rd_pulses(FB, 1'b1);
        chk("coin_rd_done", 32'(rd_done), 32'd1);
        cyc();

        // Asynchronous reset in the middle of a write frame with a read in flight.
        rd_req(1'b1, 2'd0, "mid");
        frame_start_in = 1'b1; cyc(); frame_start_in = 1'b0; cyc();
        rd_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_valid_in = 1'b1; pix_data_in = 8'hA0; cyc();
        end
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        pix_valid_in = 1'b0; rd_valid_in = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        wb0 = n_wb; re0 = n_re;
        repeat (5) cyc();
        chk("midrst_no_wr_begin", 32'(n_wb - wb0), 32'd0);
        chk("midrst_no_rd_enable", 32'(n_re - re0), 32'd0);
        rd_req(1'b0, 2'd0, "midrst_nack");
        wr_frame(FB, 1'b0, 2'd0, "restart");
        chk("restart_fv", 32'(frame_valid), 32'd1);

        // Randomized traffic against a bank-allocation model.
        m_fv = 1'b1; m_last = 2'd0; m_act = 1'b0; m_rd = 2'd0;
        for (int it = 0; it < 25; it++) begin
            if (!m_act && $urandom_range(0, 1) == 1) begin
                rd_req(m_fv, m_last, $sformatf("rnd%0d", it));
                if (m_fv) begin m_act = 1'b1; m_rd = m_last; end
            end
            b = model_free();
            wr_frame(FB + int'($urandom_range(0, 3)), 1'b1, b, $sformatf("rnd%0d", it));
            m_last = b; m_fv = 1'b1;
            chk($sformatf("rnd%0d_fv", it), 32'(frame_valid), 32'd1);
            if (m_act && $urandom_range(0, 1) == 1) begin
                rd_pulses(FB, 1'b1);
                chk($sformatf("rnd%0d_rd_done", it), 32'(rd_done), 32'd1);
                m_act = 1'b0;
                cyc();
            end
        end

        cyc();
        chk("pulse_width", 32'(pw_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr3_frame_bank_ctrl.md
# ddr3_frame_bank_ctrl

Triple-buffered frame bank controller sitting directly upstream of the AXI DDR3 adapter. Converts a byte pixel stream with frame markers into the adapter's write command (`wr_begin`, `wr_addr_begin`, `wr_data_valid`, `wr_data_in`). Converts display-side frame requests into its read command (`rd_enable`, `rd_addr_begin`). Guarantees the bank being written is never the bank being read or the latest completed frame.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32: width of bank addresses.
- `BASE_ADDR`, 32'h0000_0000: DDR address of bank 0.
- `BANK_STRIDE`, 32'h0010_0000: byte distance between banks; bank n base = `BASE_ADDR + n*BANK_STRIDE`, truncated to the address width.
- `FRAME_BYTES`, 1024: bytes per frame, ≥2; counters are `$clog2(FRAME_BYTES)+1` bits.
- `clk` in 1: single clock; all inputs synchronous to it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start_in` in 1: pulse marking the start of a write frame.
- `pix_valid_in` in 1: pixel byte strobe.
- `pix_data_in` in 8: pixel byte.
- `wr_begin` out 1: one-cycle write-start pulse to the adapter.
- `wr_addr_begin` out ADDR: write base address, valid with `wr_begin` and held afterwards.
- `wr_data_valid` out 1: byte strobe to the adapter.
- `wr_data_in` out 8: byte to the adapter.
- `rd_frame_req` in 1: pulse requesting the newest complete frame.
- `rd_valid_in` in 1: byte strobe returned by the adapter's `rd_valid_out`.
- `rd_enable` out 1: one-cycle read-start pulse to the adapter.
- `rd_addr_begin` out ADDR: read base address, valid with `rd_enable` and held.
- `rd_nack` out 1: one-cycle pulse, request refused because no frame is complete.
- `rd_done` out 1: one-cycle pulse when `FRAME_BYTES` read bytes have returned.
- `frame_valid` out 1: at least one complete frame exists.
- `wr_bank`, `rd_bank`, `last_bank` out 2 each: bank indices 0..2.
- `short_frame_err` out 1: sticky flag; cleared only by reset.

## Operation
- **Write FSM states:** W_IDLE, W_START, W_DATA, W_DONE.
  - W_IDLE → W_START on `frame_start_in`.
  - In W_START: `wr_bank` latches the lowest index that is neither `last_bank` (when `frame_valid`) nor `rd_bank` (when the read FSM is not R_IDLE). `wr_begin`=1 and `wr_addr_begin` = base of that bank. Next state is W_DATA.
  - In W_DATA: each `pix_valid_in` is forwarded registered (1-cycle latency) and increments `wr_cnt`. The `FRAME_BYTES`-th accepted byte moves the FSM to W_DONE.
  - In W_DONE (1 cycle): `last_bank`←`wr_bank`, `frame_valid`←1, then W_IDLE.
  - Pixels arriving in W_IDLE, W_START or W_DONE are dropped; `wr_data_valid` stays 0.
  - `frame_start_in` in W_DATA: set `short_frame_err`, clear `wr_cnt`, go to W_START, reselect the bank. The aborted bank is not marked complete. A pixel in that same cycle is dropped.
  - `frame_start_in` in W_START or W_DONE is ignored.
- **Read FSM states:** R_IDLE, R_START, R_BUSY.
  - `rd_frame_req` in R_IDLE with `frame_valid`=1: `rd_bank`←`last_bank`, go to R_START.
  - `rd_frame_req` in R_IDLE with `frame_valid`=0: `rd_nack` pulses next cycle; the FSM stays in R_IDLE.
  - In R_START: `rd_enable`=1 with `rd_addr_begin` = `rd_bank` base, then R_BUSY.
  - In R_BUSY: count `rd_valid_in`. At `FRAME_BYTES`, pulse `rd_done` and return to R_IDLE, which releases the bank.
  - `rd_frame_req` outside R_IDLE is ignored.
- **Simultaneous W_DONE and read accept:** the read captures the pre-update `last_bank`.
- **Bank exclusion:** with 3 banks, a free write bank always exists. `wr_bank` never equals the active `rd_bank` or the valid `last_bank`.

## Timing
- **Reset values:** all outputs 0, including both addresses, `frame_valid`, `short_frame_err` and all bank indices. Both FSMs start in their idle state and counters clear.
- **Reset assertion mid-frame:** everything returns to reset values immediately (asynchronous). No `wr_begin`/`rd_enable` pulses until a new `frame_start_in`/`rd_frame_req`.
- **Write latencies:**
  - `frame_start_in` at cycle T → `wr_begin` at T+1.
  - First forwarded pixel is the one sampled at T+2 or later; it appears on `wr_data_valid` one cycle after sampling.
  - Last byte at cycle L → `frame_valid`/`last_bank` update at L+2.
- **Read latencies:**
  - `rd_frame_req` at T → `rd_enable` at T+1, or `rd_nack` at T+1.
  - Final `rd_valid_in` at T → `rd_done` at T+1.
- `wr_begin`, `rd_enable`, `rd_nack` and `rd_done` are always exactly 1 cycle wide.

## Test plan
Use `FRAME_BYTES`=16, `BASE_ADDR`=0, `BANK_STRIDE`=0x1000.
- **Basic write:** reset, then `frame_start_in`, then 16 consecutive bytes 0x00..0x0F. Expect `wr_begin` with `wr_addr_begin`=0x0000, 16 `wr_data_valid` carrying 0x00..0x0F, then `frame_valid`=1 and `last_bank`=0.
- **Read before any frame:** `rd_frame_req` immediately after reset → `rd_nack` pulse, no `rd_enable`. After the first frame, `rd_frame_req` → `rd_enable` with `rd_addr_begin`=0x0000. 16 `rd_valid_in` pulses → `rd_done`.
- **Bank exclusion:** while reading bank 0 with `last_bank`=1, start a new frame → `wr_addr_begin`=0x2000 (bank 2).
- **Short frame:** send 5 bytes, then `frame_start_in` → `short_frame_err`=1, `frame_valid` unchanged, a new `wr_begin` issued, the 6th byte before W_DATA dropped.
- **Overflow and coincidence:** send 20 bytes in one frame → only 16 `wr_data_valid`. Align `rd_frame_req` with W_DONE of frame 2 → read gets frame 1's bank.
- **Reset mid-operation:** assert `rst_n`=0 during W_DATA/R_BUSY → all outputs 0 within the same cycle, with clean restart afterwards.
